// File: rtl/dino_pixel_pipe.sv
// Three-stage pixel renderer behind the VGA timing generator: sky, ground band, one ROM sprite
// and one obstacle, with a per-frame sprite/obstacle collision flag and syncs delayed to match.
module dino_pixel_pipe #(
   parameter int unsigned V_ACTIVE = 768,
   parameter int unsigned SPR_W    = 32,
   parameter int unsigned SPR_H    = 32,
   parameter int unsigned OBS_W    = 16,
   parameter int unsigned OBS_H    = 40,
   parameter int unsigned GROUND_Y = 600
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] h_count_i,
   input  logic [10:0] v_count_i,
   input  logic        ea_i,
   input  logic        h_sync_i,
   input  logic        v_sync_i,
   input  logic [10:0] spr_x_i,
   input  logic [10:0] spr_y_i,
   input  logic [10:0] obs_x_i,
   output logic [4:0]  rom_row_o,
   input  logic [31:0] rom_data_i,
   output logic [3:0]  vga_r_o,
   output logic [3:0]  vga_g_o,
   output logic [3:0]  vga_b_o,
   output logic        h_sync_o,
   output logic        v_sync_o,
   output logic        frame_o,
   output logic        hit_o
);

   localparam logic [10:0]        VActive  = 11'(V_ACTIVE);
   localparam logic signed [11:0] SprW     = 12'(SPR_W);
   localparam logic signed [11:0] SprH     = 12'(SPR_H);
   localparam logic signed [11:0] ObsW     = 12'(OBS_W);
   localparam logic [10:0]        ObsTop   = 11'(GROUND_Y - OBS_H);
   localparam logic [10:0]        GndFirst = 11'(GROUND_Y);
   localparam logic [10:0]        GndLast  = 11'(GROUND_Y + 3);

   localparam logic [11:0] ColBlack  = 12'h000;
   localparam logic [11:0] ColSprite = 12'hFFF;
   localparam logic [11:0] ColObs    = 12'h0A0;
   localparam logic [11:0] ColGround = 12'h840;
   localparam logic [11:0] ColSky    = 12'h48F;

   // Frame latch and shadowed object positions
   logic        v_at_active_q;
   logic        trigger;
   logic [10:0] spr_x_q, spr_y_q, obs_x_q;
   logic        frame_q, hit_q, acc_q, acc_d;

   // Stage 1
   logic signed [11:0] dx, dy, dox;
   logic               in_spr, in_obs, in_gnd;
   logic               ea1_q, hs1_q, vs1_q, in_spr1_q, in_obs1_q, in_gnd1_q;
   logic [4:0]         dx1_q, rom_row_q;

   // Stage 2
   logic       ea2_q, hs2_q, vs2_q, in_spr2_q, in_obs2_q, in_gnd2_q;
   logic [4:0] dx2_q;

   // Stage 3
   logic        spr_px, collide;
   logic [11:0] rgb_d, rgb_q;
   logic        hs3_q, vs3_q;

   assign trigger = (v_count_i == VActive) && !v_at_active_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_at_active_q <= 1'b0;
         spr_x_q       <= '0;
         spr_y_q       <= '0;
         obs_x_q       <= '0;
         frame_q       <= 1'b0;
         hit_q         <= 1'b0;
         acc_q         <= 1'b0;
      end else begin
         v_at_active_q <= (v_count_i == VActive);
         frame_q       <= trigger;
         acc_q         <= acc_d;
         if (trigger) begin
            spr_x_q <= spr_x_i;
            spr_y_q <= spr_y_i;
            obs_x_q <= obs_x_i;
            hit_q   <= acc_q;
         end
      end
   end

   // Signed 12-bit offsets clip objects hanging off either edge instead of wrapping.
   always_comb begin
      dx     = $signed({1'b0, h_count_i}) - $signed({1'b0, spr_x_q});
      dy     = $signed({1'b0, v_count_i}) - $signed({1'b0, spr_y_q});
      dox    = $signed({1'b0, h_count_i}) - $signed({1'b0, obs_x_q});
      in_spr = !dx[11] && (dx < SprW) && !dy[11] && (dy < SprH);
      in_obs = !dox[11] && (dox < ObsW) && (v_count_i >= ObsTop) && (v_count_i < GndFirst);
      in_gnd = (v_count_i >= GndFirst) && (v_count_i <= GndLast);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ea1_q     <= 1'b0;
         hs1_q     <= 1'b1;
         vs1_q     <= 1'b1;
         in_spr1_q <= 1'b0;
         in_obs1_q <= 1'b0;
         in_gnd1_q <= 1'b0;
         dx1_q     <= '0;
         rom_row_q <= '0;
      end else begin
         ea1_q     <= ea_i;
         hs1_q     <= h_sync_i;
         vs1_q     <= v_sync_i;
         in_spr1_q <= in_spr;
         in_obs1_q <= in_obs;
         in_gnd1_q <= in_gnd;
         dx1_q     <= dx[4:0];
         rom_row_q <= in_spr ? dy[4:0] : 5'd0;
      end
   end

   // The ROM registers rom_row_o, so its data arrives alongside these stage-2 flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ea2_q     <= 1'b0;
         hs2_q     <= 1'b1;
         vs2_q     <= 1'b1;
         in_spr2_q <= 1'b0;
         in_obs2_q <= 1'b0;
         in_gnd2_q <= 1'b0;
         dx2_q     <= '0;
      end else begin
         ea2_q     <= ea1_q;
         hs2_q     <= hs1_q;
         vs2_q     <= vs1_q;
         in_spr2_q <= in_spr1_q;
         in_obs2_q <= in_obs1_q;
         in_gnd2_q <= in_gnd1_q;
         dx2_q     <= dx1_q;
      end
   end

   always_comb begin
      spr_px  = in_spr2_q && rom_data_i[5'd31 - dx2_q];
      collide = ea2_q && spr_px && in_obs2_q;
      acc_d   = trigger ? 1'b0 : (acc_q | collide);
      if (!ea2_q) begin
         rgb_d = ColBlack;
      end else if (spr_px) begin
         rgb_d = ColSprite;
      end else if (in_obs2_q) begin
         rgb_d = ColObs;
      end else if (in_gnd2_q) begin
         rgb_d = ColGround;
      end else begin
         rgb_d = ColSky;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q <= ColBlack;
         hs3_q <= 1'b1;
         vs3_q <= 1'b1;
      end else begin
         rgb_q <= rgb_d;
         hs3_q <= hs2_q;
         vs3_q <= vs2_q;
      end
   end

   assign rom_row_o = rom_row_q;
   assign vga_r_o   = rgb_q[11:8];
   assign vga_g_o   = rgb_q[7:4];
   assign vga_b_o   = rgb_q[3:0];
   assign h_sync_o  = hs3_q;
   assign v_sync_o  = vs3_q;
   assign frame_o   = frame_q;
   assign hit_o     = hit_q;

endmodule

// File: tb/tb_dino_pixel_pipe.sv
// Bench for dino_pixel_pipe: constant pixel table, directed latch/collision/reset sequences and
// randomized frames, every cycle compared with a per-pixel reference model.
`timescale 1ns/1ps
module tb_dino_pixel_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [10:0] h_count, v_count, spr_x, spr_y, obs_x;
   logic        ea, h_sync, v_sync;
   logic [4:0]  rom_row;
   logic [31:0] rom_data = '0;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        h_sync_o, v_sync_o, frame, hit;
   logic [31:0] rom [32];

   int checks = 0;
   int errors = 0;

   dino_pixel_pipe dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .h_count_i  (h_count),
      .v_count_i  (v_count),
      .ea_i       (ea),
      .h_sync_i   (h_sync),
      .v_sync_i   (v_sync),
      .spr_x_i    (spr_x),
      .spr_y_i    (spr_y),
      .obs_x_i    (obs_x),
      .rom_row_o  (rom_row),
      .rom_data_i (rom_data),
      .vga_r_o    (vga_r),
      .vga_g_o    (vga_g),
      .vga_b_o    (vga_b),
      .h_sync_o   (h_sync_o),
      .v_sync_o   (v_sync_o),
      .frame_o    (frame),
      .hit_o      (hit)
   );

   always #5 clk = ~clk;

   // Registered sprite ROM
   always @(posedge clk) rom_data <= rom[rom_row];

   // Reference model state
   typedef struct {
      logic [11:0] rgb;
      bit          hs;
      bit          vs;
      bit          collide;
   } exp_t;
   exp_t q[$];
   int   m_sx, m_sy, m_ox;
   bit   m_acc, m_hit, m_prev768;

   typedef struct {
      int          sx, sy, ox, h, v;
      bit          e;
      logic [11:0] rgb;
   } vec_t;
   vec_t tbl [28];

   function automatic void ref_pix(input int h, input int v, input bit e,
                                   output logic [11:0] rgb, output bit col, output int row);
      int dx, dy, dox;
      bit spr_in, spr, obs, gnd;
      dx     = h - m_sx;
      dy     = v - m_sy;
      dox    = h - m_ox;
      spr_in = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
      spr    = 1'b0;
      if (spr_in) spr = rom[dy][31 - dx];
      obs = (dox >= 0) && (dox < 16) && (v >= 560) && (v < 600);
      gnd = (v >= 600) && (v <= 603);
      row = spr_in ? dy : 0;
      col = e && spr && obs;
      if (!e)       rgb = 12'h000;
      else if (spr) rgb = 12'hFFF;
      else if (obs) rgb = 12'h0A0;
      else if (gnd) rgb = 12'h840;
      else          rgb = 12'h48F;
   endfunction

   task automatic model_reset();
      exp_t r;
      r.rgb = 12'h000; r.hs = 1'b1; r.vs = 1'b1; r.collide = 1'b0;
      q.delete();
      q.push_back(r);
      q.push_back(r);
      m_sx = 0; m_sy = 0; m_ox = 0;
      m_acc = 1'b0; m_hit = 1'b0; m_prev768 = 1'b0;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One pixel clock: drive inputs, step, and compare everything the model predicts.
   task automatic tick(input int h, input int v, input bit e, input bit hs, input bit vs);
      exp_t x, f;
      int   row, nsx, nsy, nox;
      bit   trig, set;
      h_count = 11'(h); v_count = 11'(v); ea = e; h_sync = hs; v_sync = vs;
      ref_pix(h, v, e, x.rgb, x.collide, row);
      x.hs = hs; x.vs = vs;
      trig = (v == 768) && !m_prev768;
      m_prev768 = (v == 768);
      nsx = int'(spr_x); nsy = int'(spr_y); nox = int'(obs_x);
      @(posedge clk);
      #1;
      q.push_back(x);
      set = 1'b0;
      if (q.size() >= 3) begin
         f = q.pop_front();
         set = f.collide;
         checks++;
         if ({vga_r, vga_g, vga_b} !== f.rgb || h_sync_o !== f.hs || v_sync_o !== f.vs) begin
            errors++;
            $display("FAIL pix: rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b (t=%0t)",
                     {vga_r, vga_g, vga_b}, h_sync_o, v_sync_o, f.rgb, f.hs, f.vs, $time);
         end
      end
      if (trig) begin
         m_hit = m_acc; m_acc = 1'b0;
         m_sx = nsx; m_sy = nsy; m_ox = nox;
      end else begin
         m_acc = m_acc | set;
      end
      checks++;
      if (frame !== trig || hit !== m_hit || rom_row !== 5'(row)) begin
         errors++;
         $display("FAIL ctl: frame=%b hit=%b row=%0d, expected frame=%b hit=%b row=%0d (t=%0t)",
                  frame, hit, rom_row, trig, m_hit, row, $time);
      end
   endtask

   task automatic idle();
      tick(1100, 700, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic probe(input int h, input int v, input bit e, output logic [11:0] rgb);
      tick(h, v, e, 1'b1, 1'b1);
      idle();
      idle();
      rgb = {vga_r, vga_g, vga_b};
   endtask

   task automatic latch(input int sx, input int sy, input int ox);
      spr_x = 11'(sx); spr_y = 11'(sy); obs_x = 11'(ox);
      repeat (4) idle();
      tick(1100, 768, 1'b0, 1'b1, 1'b1);
      chk("frame_pulse", int'(frame), 1);
      idle();
      chk("frame_end", int'(frame), 0);
      idle();
   endtask

   task automatic wrap_rand(inout int h, inout int v);
      h = ((h % 1344) + 1344) % 1344;
      v = ((v % 806) + 806) % 806;
      if (v == 768) v = 767;
   endtask

   initial begin
      logic [11:0] act;
      int cs, cy, co;
      tbl = '{
         '{100, 500, 700, 100, 500, 1'b1, 12'hFFF},
         '{100, 500, 700,  99, 500, 1'b1, 12'h48F},
         '{100, 500, 700, 131, 500, 1'b1, 12'hFFF},
         '{100, 500, 700, 132, 500, 1'b1, 12'h48F},
         '{100, 500, 700, 100, 531, 1'b1, 12'hFFF},
         '{100, 500, 700, 100, 532, 1'b1, 12'h48F},
         '{100, 500, 700, 100, 499, 1'b1, 12'h48F},
         '{100, 500, 700, 700, 560, 1'b1, 12'h0A0},
         '{100, 500, 700, 715, 599, 1'b1, 12'h0A0},
         '{100, 500, 700, 716, 580, 1'b1, 12'h48F},
         '{100, 500, 700, 699, 580, 1'b1, 12'h48F},
         '{100, 500, 700, 700, 559, 1'b1, 12'h48F},
         '{100, 500, 700,  50, 600, 1'b1, 12'h840},
         '{100, 500, 700,  50, 603, 1'b1, 12'h840},
         '{100, 500, 700,  50, 604, 1'b1, 12'h48F},
         '{100, 500, 700, 705, 600, 1'b1, 12'h840},
         '{100, 500, 700, 100, 500, 1'b0, 12'h000},
         '{1020, 100,   0, 1020, 110, 1'b1, 12'hFFF},
         '{1020, 100,   0, 1023, 110, 1'b1, 12'hFFF},
         '{1020, 100,   0, 1019, 110, 1'b1, 12'h48F},
         '{1020, 100,   0, 1024, 110, 1'b0, 12'h000},
         '{1020, 100,   0,    5, 580, 1'b1, 12'h0A0},
         '{200, 560, 210, 210, 570, 1'b1, 12'hFFF},
         '{200, 560, 210, 215, 595, 1'b1, 12'h0A0},
         '{200, 560, 210, 228, 595, 1'b1, 12'h48F},
         '{2040, 100, 2040, 5, 110, 1'b1, 12'h48F},
         '{2040, 100, 2040, 3, 580, 1'b1, 12'h48F},
         '{2040, 100, 2040, 0, 100, 1'b1, 12'h48F}
      };
      for (int i = 0; i < 32; i++) rom[i] = 32'hFFFF_FFFF;
      h_count = '0; v_count = '0; ea = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
      spr_x = '0; spr_y = '0; obs_x = '0;
      #22;
      rst_n = 1'b1;
      model_reset();

      // Constant pixel table
      cs = -1; cy = -1; co = -1;
      for (int i = 0; i < 28; i++) begin
         if (tbl[i].sx != cs || tbl[i].sy != cy || tbl[i].ox != co) begin
            latch(tbl[i].sx, tbl[i].sy, tbl[i].ox);
            cs = tbl[i].sx; cy = tbl[i].sy; co = tbl[i].ox;
         end
         probe(tbl[i].h, tbl[i].v, tbl[i].e, act);
         chk($sformatf("tbl%0d", i), int'(act), int'(tbl[i].rgb));
      end

      // Sync latency: falls exactly three clocks after the input
      tick(1100, 780, 1'b0, 1'b0, 1'b0);
      chk("hs_lat1", int'(h_sync_o), 1);
      tick(1100, 780, 1'b0, 1'b1, 1'b1);
      chk("vs_lat2", int'(v_sync_o), 1);
      tick(1100, 780, 1'b0, 1'b1, 1'b1);
      chk("hs_lat3", int'(h_sync_o), 0);
      chk("vs_lat3", int'(v_sync_o), 0);

      // Shadowing: mid-frame position change waits for the next latch
      latch(100, 500, 700);
      spr_x = 11'd300;
      tick(50, 200, 1'b1, 1'b1, 1'b1);
      probe(100, 500, 1'b1, act);
      chk("shadow_old", int'(act), 'hFFF);
      probe(300, 500, 1'b1, act);
      chk("shadow_new_early", int'(act), 'h48F);
      latch(300, 500, 700);
      probe(300, 500, 1'b1, act);
      chk("shadow_new", int'(act), 'hFFF);
      probe(100, 500, 1'b1, act);
      chk("shadow_old_gone", int'(act), 'h48F);

      // Collision reported after the latch, cleared one frame after moving away
      latch(200, 560, 210);
      probe(215, 570, 1'b1, act);
      latch(200, 560, 500);
      chk("hit_set", int'(hit), 1);
      probe(215, 570, 1'b1, act);
      probe(505, 570, 1'b1, act);
      latch(200, 560, 210);
      chk("hit_clear", int'(hit), 0);
      probe(215, 570, 1'b1, act);
      latch(200, 560, 210);
      chk("hit_again", int'(hit), 1);

      // Asynchronous reset mid-line with white pixels and low syncs in flight
      repeat (3) tick(215, 570, 1'b1, 1'b0, 1'b0);
      chk("pre_reset_rgb", int'({vga_r, vga_g, vga_b}), 'hFFF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
      chk("rst_hs", int'(h_sync_o), 1);
      chk("rst_vs", int'(v_sync_o), 1);
      chk("rst_hit", int'(hit), 0);
      chk("rst_frame", int'(frame), 0);
      chk("rst_row", int'(rom_row), 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (5) tick(215, 570, 1'b1, 1'b1, 1'b1);
      chk("hit_after_reset", int'(hit), 0);

      // Leftmost-pixel bit ordering at column 0
      for (int i = 0; i < 32; i++) rom[i] = 32'h0;
      rom[0] = 32'h8000_0000;
      latch(0, 0, 700);
      probe(0, 0, 1'b1, act);
      chk("bit31_h0", int'(act), 'hFFF);
      probe(1, 0, 1'b1, act);
      chk("bit31_h1", int'(act), 'h48F);

      // Randomized frames against the model
      for (int f = 0; f < 30; f++) begin
         int sx, sy, ox, h, v;
         repeat (3) idle();
         for (int i = 0; i < 32; i++) rom[i] = (f % 3 == 0) ? 32'hFFFF_FFFF : $urandom;
         sy = ($urandom_range(1) == 1) ? 540 + $urandom_range(50) : $urandom_range(800);
         sx = ($urandom_range(4) == 0) ? 2020 + $urandom_range(27) : $urandom_range(1100);
         ox = ($urandom_range(1) == 1) ? sx - 20 + $urandom_range(60) : $urandom_range(1100);
         latch(sx & 'h7FF, sy & 'h7FF, ox & 'h7FF);
         for (int i = 0; i < 200; i++) begin
            if ($urandom_range(15) == 0) begin
               spr_x = 11'($urandom); spr_y = 11'($urandom); obs_x = 11'($urandom);
            end
            case ($urandom_range(2))
               0: begin h = m_sx - 3 + $urandom_range(37); v = m_sy - 3 + $urandom_range(37); end
               1: begin h = m_ox - 3 + $urandom_range(21); v = 555 + $urandom_range(50); end
               default: begin h = $urandom_range(1343); v = $urandom_range(805); end
            endcase
            wrap_rand(h, v);
            tick(h, v, (h < 1024) && (v < 768), !((h >= 1048) && (h < 1184)),
                 !((v >= 771) && (v < 777)));
         end
      end
      repeat (4) idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
